// File: rtl/matmul_sequencer_if.sv
// Bus bundle between the matmul sequencer and its surroundings.
//   master : sequencer side (drives RAM addresses, MAC controls, result port)
//   slave  : operand RAMs, MAC unit and result consumer
// Signals:
//   a_addr/b_addr    operand RAM addresses (row-major)
//   a_rdata/b_rdata  operand RAM data, one cycle after the address
//   mac_en/mac_first MAC strobe and "load instead of accumulate"
//   mac_a/mac_b      MAC operands
//   mac_acc          MAC accumulator value
//   result/res_i/res_j/res_valid/res_ready  finished-element handshake
interface matmul_sequencer_if #(
  parameter int DW = 16,
  parameter int AW = 8
);
  logic [AW-1:0]   a_addr, b_addr;
  logic [DW-1:0]   a_rdata, b_rdata;
  logic            mac_en, mac_first;
  logic [DW-1:0]   mac_a, mac_b;
  logic [2*DW-1:0] mac_acc;
  logic [2*DW-1:0] result;
  logic [31:0]     res_i, res_j;
  logic            res_valid, res_ready;

  modport master (
    output a_addr, b_addr, mac_en, mac_first, mac_a, mac_b,
           result, res_i, res_j, res_valid,
    input  a_rdata, b_rdata, mac_acc, res_ready
  );

  modport slave (
    input  a_addr, b_addr, mac_en, mac_first, mac_a, mac_b,
           result, res_i, res_j, res_valid,
    output a_rdata, b_rdata, mac_acc, res_ready
  );
endinterface

// File: rtl/matmul_sequencer.sv
// Control FSM for one (R_A x C_A) * (C_A x C_B) signed matrix product.
// Walks result indices (i,j) and inner index k, issues one A/B address pair
// per cycle, strobes an external MAC one cycle later (RAM latency) and
// presents each finished element on a valid/ready port.
// Ports:
//   clk      clock
//   rst      asynchronous active-low reset
//   start_i  begin a product (sampled only in IDLE)
//   busy_o   high in every state except IDLE
//   done_o   one-cycle pulse after the last element is accepted
//   bus      matmul_sequencer_if.master (RAM, MAC and result signals)
module matmul_sequencer #(
  parameter int R_A = 2,
  parameter int C_A = 4,
  parameter int C_B = 2,
  parameter int DW  = 16,
  parameter int AW  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  matmul_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_DRAIN, S_OUTPUT, S_DONE
  } state_e;

  localparam logic [31:0]   I_LAST = 32'(R_A - 1);
  localparam logic [31:0]   J_LAST = 32'(C_B - 1);
  localparam logic [31:0]   K_LAST = 32'(C_A - 1);
  localparam logic [AW-1:0] CA_W   = AW'(C_A);
  localparam logic [AW-1:0] CB_W   = AW'(C_B);

  state_e      state_q, state_d;
  logic [31:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic        mac_en_q, mac_first_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      mac_en_q    <= 1'b0;
      mac_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      // RAM data for the pair issued this cycle arrives next cycle, so the
      // MAC strobe is the issue flag delayed by one.
      mac_en_q    <= (state_q == S_ISSUE);
      mac_first_q <= (state_q == S_ISSUE) && (k_q == '0);
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_ISSUE;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end
      S_ISSUE: begin
        if (k_q < K_LAST) begin
          k_d = k_q + 32'd1;
        end else begin
          k_d     = '0;
          state_d = S_DRAIN;
        end
      end
      // One cycle for the last pair's data to reach the MAC.
      S_DRAIN: state_d = S_OUTPUT;
      S_OUTPUT: begin
        if (bus.res_ready) begin
          if (j_q < J_LAST) begin
            j_d     = j_q + 32'd1;
            state_d = S_ISSUE;
          end else if (i_q < I_LAST) begin
            j_d     = '0;
            i_d     = i_q + 32'd1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        i_d     = '0;
        j_d     = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Unsigned AW-bit address arithmetic; wraps if AW is undersized.
  assign bus.a_addr    = AW'(i_q) * CA_W + AW'(k_q);
  assign bus.b_addr    = AW'(k_q) * CB_W + AW'(j_q);
  assign bus.mac_en    = mac_en_q;
  assign bus.mac_first = mac_first_q;
  assign bus.mac_a     = bus.a_rdata;
  assign bus.mac_b     = bus.b_rdata;

  assign bus.res_valid = (state_q == S_OUTPUT);
  assign bus.result    = (state_q == S_OUTPUT) ? bus.mac_acc : '0;
  assign bus.res_i     = (state_q == S_OUTPUT) ? i_q : '0;
  assign bus.res_j     = (state_q == S_OUTPUT) ? j_q : '0;

  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_DONE);

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: default build (2x4 * 4x2) plus a C_A=1 build,
// with behavioural operand RAMs and MAC around each instance.
module tb_matmul_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic start = 1'b0, start1 = 1'b0;
  logic busy, busy1, done, done1;

  matmul_sequencer_if #(.DW(16), .AW(8)) bus ();
  matmul_sequencer_if #(.DW(16), .AW(8)) bus1 ();

  matmul_sequencer #(.R_A(2), .C_A(4), .C_B(2), .DW(16), .AW(8)) dut (
    .clk(clk), .rst(rst), .start_i(start), .busy_o(busy), .done_o(done),
    .bus(bus.master)
  );
  matmul_sequencer #(.R_A(2), .C_A(1), .C_B(2), .DW(16), .AW(8)) dut1 (
    .clk(clk), .rst(rst), .start_i(start1), .busy_o(busy1), .done_o(done1),
    .bus(bus1.master)
  );

  logic signed [15:0] mem_a[256], mem_b[256], mem_a1[256], mem_b1[256];

  function automatic logic signed [31:0] mul(input logic signed [15:0] a, input logic signed [15:0] b);
    logic signed [31:0] x, y;
    x = a;
    y = b;
    return x * y;
  endfunction

  // RAM (1-cycle read) and MAC models
  always @(posedge clk) begin
    bus.a_rdata  <= mem_a[bus.a_addr];
    bus.b_rdata  <= mem_b[bus.b_addr];
    bus1.a_rdata <= mem_a1[bus1.a_addr];
    bus1.b_rdata <= mem_b1[bus1.b_addr];
    if (bus.mac_en)
      bus.mac_acc <= bus.mac_first ? mul(bus.mac_a, bus.mac_b) : bus.mac_acc + mul(bus.mac_a, bus.mac_b);
    if (bus1.mac_en)
      bus1.mac_acc <= bus1.mac_first ? mul(bus1.mac_a, bus1.mac_b) : bus1.mac_acc + mul(bus1.mac_a, bus1.mac_b);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [31:0] rq[$], rq1[$];
  int iq[$], jq[$], iq1[$], jq1[$];
  logic [7:0] tra[$], trb[$];
  logic trf[$];
  logic [7:0] pa = '0, pb = '0;
  int done_cnt = 0, done1_cnt = 0, done_cyc = 0, mac_in_out = 0, nofirst1 = 0, s_cyc = 0;

  // Monitor: accepted results, MAC address trace (address of previous cycle), done pulses
  always @(negedge clk) begin
    if (bus.mac_en) begin
      tra.push_back(pa); trb.push_back(pb); trf.push_back(bus.mac_first);
    end
    pa = bus.a_addr;
    pb = bus.b_addr;
    if (bus.res_valid && bus.res_ready) begin
      rq.push_back($signed(bus.result)); iq.push_back(int'(bus.res_i)); jq.push_back(int'(bus.res_j));
    end
    if (bus.mac_en && bus.res_valid) mac_in_out++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (bus1.res_valid && bus1.res_ready) begin
      rq1.push_back($signed(bus1.result)); iq1.push_back(int'(bus1.res_i)); jq1.push_back(int'(bus1.res_j));
    end
    if (bus1.mac_en && !bus1.mac_first) nofirst1++;
    if (done1) done1_cnt++;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    rq.delete(); iq.delete(); jq.delete();
    rq1.delete(); iq1.delete(); jq1.delete();
    tra.delete(); trb.delete(); trf.delete();
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start1 = 1'b1; else start = 1'b1;
    tick(1);
    start = 1'b0;
    start1 = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic wait_done(input string tag, input bit sel);
    int d0, n;
    d0 = sel ? done1_cnt : done_cnt;
    n = 0;
    while ((sel ? done1_cnt : done_cnt) == d0 && n < 500) begin
      tick(1);
      n++;
    end
    chk(tag, (sel ? done1_cnt : done_cnt) - d0, 1);
  endtask

  task automatic check_results(input string tag, input bit sel,
                               input int e0, input int e1, input int e2, input int e3);
    logic signed [31:0] r[$];
    int ii[$], jj[$];
    int e[4];
    e = '{e0, e1, e2, e3};
    if (sel) begin r = rq1; ii = iq1; jj = jq1; end
    else begin r = rq; ii = iq; jj = jq; end
    chk({tag, "_count"}, r.size(), 4);
    if (r.size() == 4) begin
      for (int n = 0; n < 4; n++) begin
        chk($sformatf("%s_res%0d", tag, n), r[n], e[n]);
        chk($sformatf("%s_i%0d", tag, n), ii[n], n / 2);
        chk($sformatf("%s_j%0d", tag, n), jj[n], n % 2);
      end
    end
  endtask

  task automatic load_seq();
    for (int n = 0; n < 8; n++) begin
      mem_a[n] = 16'(n + 1);
      mem_b[n] = 16'(n + 1);
    end
  endtask

  initial begin
    int held, m0, d0;
    bus.res_ready = 1'b1;
    bus1.res_ready = 1'b1;
    for (int n = 0; n < 256; n++) begin
      mem_a[n] = '0; mem_b[n] = '0; mem_a1[n] = '0; mem_b1[n] = '0;
    end

    // Reset state
    tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", bus.res_valid, 0);
    chk("rst_mac_en", bus.mac_en, 0);
    chk("rst_a_addr", bus.a_addr, 0);
    chk("rst_b_addr", bus.b_addr, 0);
    rst = 1'b1;
    tick(2);

    // Basic product A=1..8, B=1..8
    load_seq();
    clear_q();
    pulse_start(0);
    chk("busy_after_start", busy, 1);
    wait_done("basic_done", 0);
    chk("basic_done_latency", done_cyc - s_cyc, 24);
    chk("basic_idle", busy, 0);
    check_results("basic", 0, 50, 60, 114, 140);
    chk("trace_count", tra.size(), 16);
    if (tra.size() == 16) begin
      for (int n = 0; n < 4; n++) begin
        chk($sformatf("trace_a%0d", n), tra[12+n], 4 + n);
        chk($sformatf("trace_b%0d", n), trb[12+n], 1 + 2 * n);
        chk($sformatf("trace_first%0d", n), trf[12+n], (n == 0) ? 1 : 0);
      end
    end

    // Stall on first element
    clear_q();
    bus.res_ready = 1'b0;
    pulse_start(0);
    held = 0;
    while (!bus.res_valid && held < 50) begin tick(1); held++; end
    chk("stall_valid", bus.res_valid, 1);
    m0 = mac_in_out;
    held = 0;
    for (int n = 0; n < 5; n++) begin
      tick(1);
      if (bus.res_valid === 1'b1 && $signed(bus.result) === 50 &&
          bus.res_i === 32'd0 && bus.res_j === 32'd0) held++;
    end
    chk("stall_hold_cycles", held, 5);
    chk("stall_result", $signed(bus.result), 50);
    chk("stall_no_mac", mac_in_out - m0, 0);
    bus.res_ready = 1'b1;
    tick(1);
    chk("accept_valid_drop", bus.res_valid, 0);
    chk("accept_busy", busy, 1);
    wait_done("stall_done", 0);
    check_results("stall", 0, 50, 60, 114, 140);

    // Start pulses while busy, and start coincident with done
    clear_q();
    pulse_start(0);
    d0 = done_cnt;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (done) begin start = 1'b1; break; end
      start = (n % 7 == 3);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_at_done_ignored", busy, 0);
    tick(10);
    chk("done_once", done_cnt - d0, 1);
    chk("stays_idle", busy, 0);
    check_results("hammer", 0, 50, 60, 114, 140);

    // Reset mid-ISSUE of element (0,1)
    clear_q();
    pulse_start(0);
    tick(7);
    chk("pre_rst_mac_en", bus.mac_en, 1);
    chk("pre_rst_a_addr", bus.a_addr, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_mac_en", bus.mac_en, 0);
    chk("mid_rst_mac_first", bus.mac_first, 0);
    chk("mid_rst_valid", bus.res_valid, 0);
    chk("mid_rst_a_addr", bus.a_addr, 0);
    chk("mid_rst_b_addr", bus.b_addr, 0);
    chk("mid_rst_result", bus.result, 0);
    tick(2);
    rst = 1'b1;
    tick(1);
    clear_q();
    pulse_start(0);
    wait_done("rerun_done", 0);
    chk("rerun_latency", done_cyc - s_cyc, 24);
    check_results("rerun", 0, 50, 60, 114, 140);

    // Signed operands
    for (int n = 0; n < 8; n++) begin
      mem_a[n] = -16'sd1;
      mem_b[n] = 16'sd32767;
    end
    clear_q();
    tick(1);
    pulse_start(0);
    wait_done("signed_done", 0);
    check_results("signed", 0, -131068, -131068, -131068, -131068);

    // C_A = 1 build
    mem_a1[0] = 16'sd3;  mem_a1[1] = -16'sd4;
    mem_b1[0] = 16'sd5;  mem_b1[1] = -16'sd7;
    clear_q();
    m0 = nofirst1;
    pulse_start(1);
    wait_done("ca1_done", 1);
    chk("ca1_first_always", nofirst1 - m0, 0);
    chk("ca1_idle", busy1, 0);
    check_results("ca1", 1, 15, -21, -20, 28);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
